// File: rtl/uut_exec_ctrl.sv
// Sequencer between autotest control and the Twofish UUT.
// Optional run timeout: define UUT_TIMEOUT_EN.
module uut_exec_ctrl #(
  parameter int DATA_W     = 128,
  parameter int KEY_W      = 128,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] block_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic              encdec_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] result_o,
  output logic [CNT_W-1:0]  cycles_o,
  output logic              rst_uut_o,
  output logic [DATA_W-1:0] block_uut_o,
  output logic [KEY_W-1:0]  key_uut_o,
  output logic              encdec_uut_o,
  input  logic [DATA_W-1:0] block_uut_i,
  input  logic              end_uut_i
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    DONE
  } state_t;

  localparam int LC_W =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [LC_W-1:0] LC_LAST =
    LC_W'(RST_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [LC_W-1:0]   lcnt;
  logic [CNT_W-1:0]  rcnt;
  logic              accept;
  logic              load_last;
  logic              cnt_max;
  logic              to_hit;

  assign accept    = (state == IDLE) && start_i;
  assign load_last = (lcnt == LC_LAST);
  assign cnt_max   = &rcnt;

`ifdef UUT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL =
    CNT_W'(TIMEOUT);

  assign to_hit = (state == RUN) &&
                  !end_uut_i &&
                  (rcnt == TO_LAST);
`else
  // Constant false; keeps TIMEOUT referenced.
  assign to_hit = 1'b0 && (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rst_uut_o = 1'b1;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (load_last) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        rst_uut_o = 1'b0;
        if (end_uut_i) begin
          state_nxt = CAPTURE;
        end else if (to_hit) begin
          state_nxt = DONE;
        end
      end
      CAPTURE: begin
        rst_uut_o = 1'b0;
        state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt         <= '0;
      rcnt         <= '0;
      block_uut_o  <= '0;
      key_uut_o    <= '0;
      encdec_uut_o <= 1'b0;
      result_o     <= '0;
      cycles_o     <= '0;
    end else begin
      if (accept) begin
        block_uut_o  <= block_i;
        key_uut_o    <= key_i;
        encdec_uut_o <= encdec_i;
        lcnt         <= '0;
      end
      if (state == LOAD) begin
        lcnt <= lcnt + 1'b1;
        rcnt <= '0;
      end
      if (state == RUN && !end_uut_i && !cnt_max) begin
        rcnt <= rcnt + 1'b1;
      end
      if (state == CAPTURE) begin
        result_o <= block_uut_i;
        cycles_o <= rcnt;
      end
`ifdef UUT_TIMEOUT_EN
      if (to_hit) begin
        result_o <= '0;
        cycles_o <= TO_VAL;
      end
`endif
    end
  end

`ifdef UUT_TIMEOUT_EN
  // Sticky until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_o <= 1'b0;
    end else if (accept) begin
      timeout_o <= 1'b0;
    end else if (to_hit) begin
      timeout_o <= 1'b1;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uut_exec_ctrl.sv
// Directed self-checking bench for uut_exec_ctrl.
// Timeout steps run only with UUT_TIMEOUT_EN defined.
module tb_uut_exec_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [127:0] block_i;
  logic [127:0] key_i;
  logic         encdec_i;
  logic         busy_o;
  logic         done_o;
  logic         timeout_o;
  logic [127:0] result_o;
  logic [31:0]  cycles_o;
  logic         rst_uut_o;
  logic [127:0] block_uut_o;
  logic [127:0] key_uut_o;
  logic         encdec_uut_o;
  logic [127:0] block_uut_i;
  logic         end_uut_i;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] OUT1 =
    128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
  localparam logic [127:0] JUNK =
    128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  uut_exec_ctrl #(
    .DATA_W(128),
    .KEY_W(128),
    .CNT_W(32),
    .RST_CYCLES(4),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .block_i(block_i),
    .key_i(key_i),
    .encdec_i(encdec_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .timeout_o(timeout_o),
    .result_o(result_o),
    .cycles_o(cycles_o),
    .rst_uut_o(rst_uut_o),
    .block_uut_o(block_uut_o),
    .key_uut_o(key_uut_o),
    .encdec_uut_o(encdec_uut_o),
    .block_uut_i(block_uut_i),
    .end_uut_i(end_uut_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Pulses start, models a UUT ending at run cycle k
  // (cycle n = k+5 after start), bounded to 300 cycles.
  task automatic run_vec(input int k,
                         input logic [127:0] outv,
                         input bit lnoise,
                         input bit snoise,
                         output int done_at,
                         output int ndone,
                         output int rst_bad);
    bit exp_rst;
    done_at = -1;
    ndone   = 0;
    rst_bad = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int n = 1; n < 300; n++) begin
      if (done_o) begin
        ndone++;
        if (done_at < 0) done_at = n;
        if (rst_uut_o !== 1'b1) rst_bad++;
      end else begin
        exp_rst = (n <= 4) || (n > k + 6);
        if (rst_uut_o !== exp_rst) rst_bad++;
      end
      end_uut_i   = (n >= k + 5) || (lnoise && n == 2);
      block_uut_i = (n >= k + 5) ? outv : JUNK;
      start_i     = snoise &&
                    (n == 3 || n == 8 || n == k + 7);
      if (start_i) begin
        block_i  = ~block_i;
        key_i    = ~key_i;
        encdec_i = ~encdec_i;
      end
      tick();
      if (done_at > 0 && n >= done_at + 2) break;
    end
    start_i   = 1'b0;
    end_uut_i = 1'b0;
  endtask

  int d_at;
  int nd;
  int rb;

  initial begin
    rst         = 1'b1;
    start_i     = 1'b0;
    block_i     = '0;
    key_i       = '0;
    encdec_i    = 1'b0;
    block_uut_i = '0;
    end_uut_i   = 1'b0;
    tick();
    tick();
    check("rst_rst_uut", 128'(rst_uut_o), 128'd1);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_done", 128'(done_o), 128'd0);
    check("rst_timeout", 128'(timeout_o), 128'd0);
    check("rst_result", result_o, 128'd0);
    check("rst_cycles", 128'(cycles_o), 128'd0);
    check("rst_block_uut", block_uut_o, 128'd0);
    rst = 1'b0;
    tick();
    check("idle_rst_uut", 128'(rst_uut_o), 128'd1);

    // Basic run
    block_i  = '0;
    key_i    = '0;
    encdec_i = 1'b1;
    run_vec(16, OUT1, 1'b0, 1'b0, d_at, nd, rb);
    check("basic_latency", 128'(d_at), 128'd23);
    check("basic_ndone", 128'(nd), 128'd1);
    check("basic_rst_uut", 128'(rb), 128'd0);
    check("basic_result", result_o, OUT1);
    check("basic_cycles", 128'(cycles_o), 128'd16);
    check("basic_busy_after", 128'(busy_o), 128'd0);
    check("basic_encdec", 128'(encdec_uut_o), 128'd1);
    check("basic_timeout", 128'(timeout_o), 128'd0);

    // Busy ignore
    block_i  = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    key_i    = 128'h3C3C_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    encdec_i = 1'b0;
    run_vec(7, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978,
            1'b0, 1'b1, d_at, nd, rb);
    check("busy_block_uut", block_uut_o,
          128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    check("busy_key_uut", key_uut_o,
          128'h3C3C_7777_8888_9999_AAAA_BBBB_CCCC_DDDD);
    check("busy_encdec_uut", 128'(encdec_uut_o), 128'd0);
    check("busy_ndone", 128'(nd), 128'd1);
    check("busy_latency", 128'(d_at), 128'd14);
    check("busy_cycles", 128'(cycles_o), 128'd7);
    check("busy_rst_uut", 128'(rb), 128'd0);
    check("busy_idle_after", 128'(busy_o), 128'd0);
    check("busy_result", result_o,
          128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);

    // Immediate end, with end pulse in LOAD
    block_i  = 128'h1;
    key_i    = 128'h2;
    encdec_i = 1'b1;
    run_vec(0, 128'hFACE, 1'b1, 1'b0, d_at, nd, rb);
    check("imm_cycles", 128'(cycles_o), 128'd0);
    check("imm_latency", 128'(d_at), 128'd7);
    check("imm_ndone", 128'(nd), 128'd1);
    check("imm_rst_uut", 128'(rb), 128'd0);
    check("imm_result", result_o, 128'hFACE);
    tick();
    tick();
    check("imm_result_hold", result_o, 128'hFACE);

    // Mid-run reset, start in same cycle as rst
    block_i  = 128'h55;
    key_i    = 128'h66;
    encdec_i = 1'b1;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    check("mid_busy_run", 128'(busy_o), 128'd1);
    check("mid_rst_uut_run", 128'(rst_uut_o), 128'd0);
    rst     = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    rst     = 1'b0;
    check("mid_rst_uut", 128'(rst_uut_o), 128'd1);
    check("mid_busy", 128'(busy_o), 128'd0);
    check("mid_done", 128'(done_o), 128'd0);
    check("mid_result", result_o, 128'd0);
    check("mid_cycles", 128'(cycles_o), 128'd0);
    check("mid_block_uut", block_uut_o, 128'd0);
    check("mid_key_uut", key_uut_o, 128'd0);
    check("mid_encdec_uut", 128'(encdec_uut_o), 128'd0);
    nd = 0;
    for (int n = 0; n < 30; n++) begin
      if (done_o || busy_o) nd++;
      tick();
    end
    check("mid_no_done", 128'(nd), 128'd0);

    // Fresh start after reset
    block_i  = 128'h77;
    key_i    = 128'h88;
    encdec_i = 1'b0;
    run_vec(3, 128'hBEEF, 1'b0, 1'b0, d_at, nd, rb);
    check("fresh_latency", 128'(d_at), 128'd10);
    check("fresh_cycles", 128'(cycles_o), 128'd3);
    check("fresh_result", result_o, 128'hBEEF);
    check("fresh_block_uut", block_uut_o, 128'h77);
    check("fresh_ndone", 128'(nd), 128'd1);

`ifdef UUT_TIMEOUT_EN
    // UUT never ends
    run_vec(100000, JUNK, 1'b0, 1'b0, d_at, nd, rb);
    check("to_latency", 128'(d_at), 128'd69);
    check("to_ndone", 128'(nd), 128'd1);
    check("to_flag", 128'(timeout_o), 128'd1);
    check("to_cycles", 128'(cycles_o), 128'd64);
    check("to_result", result_o, 128'd0);
    check("to_rst_uut", 128'(rb), 128'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("to_clear", 128'(timeout_o), 128'd0);
    for (int n = 0; n < 120 && busy_o; n++) tick();
    check("to_next_idle", 128'(busy_o), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/uut_exec_ctrl.md
Name: uut_exec_ctrl

Overview:
Execution sequencer placed between the autotest controller and the Twofish UUT.
- Latches one test vector (block, key, enc/dec) and drives it stable onto the UUT ports.
- Holds the UUT in reset, releases it, and waits for end_signal.
- Captures text_output and the number of cycles the UUT ran, then reports done to the autotest side.

Parameters:
DATA_W, 128, width of the UUT text input/output
KEY_W, 128, width of the UUT key
CNT_W, 32, width of the run-cycle counter
RST_CYCLES, 4, cycles the UUT reset is held asserted after start (≥1)
TIMEOUT, 1048576, maximum run cycles before abort (used only with UUT_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_i  in  1  one-cycle request to run one vector
block_i  in  DATA_W  plaintext/ciphertext to apply
key_i  in  KEY_W  key to apply
encdec_i  in  1  encrypt/decrypt select to apply
busy_o  out  1  high from accepted start until done
done_o  out  1  one-cycle completion pulse
timeout_o  out  1  last run aborted by timeout
result_o  out  DATA_W  captured UUT output
cycles_o  out  CNT_W  captured run-cycle count
rst_uut_o  out  1  reset to UUT
block_uut_o  out  DATA_W  to UUT text_input
key_uut_o  out  KEY_W  to UUT key
encdec_uut_o  out  1  to UUT enc_dec
block_uut_i  in  DATA_W  from UUT text_output
end_uut_i  in  1  from UUT end_signal

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values:
  - rst_uut_o=1; the UUT is held in reset whenever the sequencer is idle.
  - busy_o, done_o and timeout_o are 0.
  - result_o, cycles_o, block_uut_o, key_uut_o and encdec_uut_o are 0.
  - Counters are 0 and the state is IDLE.
- FSM states: IDLE, LOAD, RUN, CAPTURE, DONE.
- IDLE:
  - rst_uut_o=1, busy_o=0.
  - On start_i=1: block_i, key_i and encdec_i are registered into the *_uut_o outputs, timeout_o is cleared, busy_o goes to 1 next cycle, and the state moves to LOAD.
- LOAD:
  - rst_uut_o=1 for exactly RST_CYCLES cycles, then the state moves to RUN.
  - end_uut_i is ignored.
- RUN:
  - rst_uut_o=0.
  - The run counter starts at 0 on entry and increments every RUN cycle in which end_uut_i=0.
  - In a RUN cycle with end_uut_i=1, the state moves to CAPTURE and the count is frozen; first-cycle end gives count 0.
  - The counter saturates at all-ones and does not wrap.
- CAPTURE (1 cycle): result_o <= block_uut_i, cycles_o <= count, rst_uut_o stays 0.
- DONE (1 cycle): done_o=1, rst_uut_o=1; busy_o=0 from the following cycle, and the state returns to IDLE.
- Latency from start_i to done_o (end at run cycle k): RST_CYCLES + k + 3 cycles.
- The *_uut_o vector outputs are stable from LOAD entry until the next accepted start.
- result_o and cycles_o hold their values until the next capture.
- start_i while busy_o=1, or in the DONE cycle, is ignored; there is no queueing.
- A start_i asserted in the same cycle as rst is ignored.
- rst mid-run returns all state to reset values on the next edge; no done_o is produced.

Optional Feature:
UUT_TIMEOUT_EN.
- Defined:
  - In RUN, if the count reaches TIMEOUT-1 with end_uut_i still 0, the next state is DONE and CAPTURE is skipped.
  - result_o<=0, cycles_o<=TIMEOUT and timeout_o<=1; timeout_o is sticky until the next accepted start.
  - done_o pulses as normal.
- Undefined: no timeout; RUN waits indefinitely, timeout_o is tied to 0, and TIMEOUT is unused.

Test Plan:
- Basic run:
  - Stimulus: RST_CYCLES=4; start with block=0x0 and key=0x0, encdec=1; the model UUT asserts end at run cycle 16 with output 0x9F589F5CF6122C32B6BFEC2F2AE8C35A.
  - Required: result_o equals that output, cycles_o=16, done_o 1 cycle, 23 cycles after start_i.
- Reset hold:
  - Stimulus: monitor rst_uut_o across a run.
  - Required: high in idle; high for exactly 4 cycles after start; low until capture; high again in DONE.
- Busy ignore:
  - Stimulus: start_i pulses during LOAD and RUN with different data.
  - Required: *_uut_o unchanged and exactly one done_o.
- Immediate end:
  - Stimulus: end_uut_i=1 in the first RUN cycle.
  - Required: cycles_o=0.
  - Stimulus: end_uut_i=1 during LOAD.
  - Required: ignored.
- Mid-run reset:
  - Stimulus: assert rst in RUN cycle 5.
  - Required: all outputs at reset values next cycle and no done_o.
  - Stimulus: a fresh start afterwards.
  - Required: completes normally.
- Timeout (UUT_TIMEOUT_EN, TIMEOUT=64):
  - Stimulus: the UUT never ends.
  - Required: done_o with timeout_o=1, cycles_o=64, result_o=0.
  - Stimulus: the next start.
  - Required: timeout_o clears.
